// File: rtl/cla_pkg.sv
// Shared constants, 4-bit carry-lookahead group function and saturation helpers
// for the pipelined CLA adder/subtractor.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  typedef struct packed {
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
  } grp_pg_t;

  typedef struct packed {
    logic               cout;
    logic               cmsb;
    logic [GROUP_W-1:0] sum;
  } grp_res_t;

  function automatic int unsigned stages(input int unsigned width);
    return width / GROUP_W;
  endfunction

  function automatic grp_res_t cla4(input logic [GROUP_W-1:0] a,
                                    input logic [GROUP_W-1:0] b,
                                    input logic               c0);
    grp_pg_t            pg;
    logic [GROUP_W:0]   c;
    grp_res_t           r;
    pg.p = a ^ b;
    pg.g = a & b;
    c[0] = c0;
    c[1] = pg.g[0] | (pg.p[0] & c0);
    c[2] = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & c0);
    c[3] = pg.g[2] | (pg.p[2] & pg.g[1]) | (pg.p[2] & pg.p[1] & pg.g[0])
         | (pg.p[2] & pg.p[1] & pg.p[0] & c0);
    c[4] = pg.g[3] | (pg.p[3] & pg.g[2]) | (pg.p[3] & pg.p[2] & pg.g[1])
         | (pg.p[3] & pg.p[2] & pg.p[1] & pg.g[0])
         | (pg.p[3] & pg.p[2] & pg.p[1] & pg.p[0] & c0);
    r.sum  = pg.p ^ c[GROUP_W-1:0];
    r.cmsb = c[GROUP_W-1];
    r.cout = c[GROUP_W];
    return r;
  endfunction

  // Returns {msb, fill for every lower bit} of the saturated result.
  function automatic logic [1:0] sat_pattern(input logic sgn, input logic a_msb,
                                             input logic sub);
    if (sgn) return a_msb ? 2'b10 : 2'b01;
    return sub ? 2'b00 : 2'b11;
  endfunction

endpackage

// File: rtl/cla_group_stage.sv
// One pipeline stage: 4-bit CLA group IDX plus its valid/operand/result/carry
// register and elastic load control.
module cla_group_stage
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prev_valid,
  input  logic             take,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_s,
  input  logic             prev_c,
  input  logic             prev_sub,
  output logic             valid,
  output logic             load,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q,
  output logic             c_q,
  output logic             c_msb_q,
  output logic             sub_q
);

  grp_res_t         r;
  logic [WIDTH-1:0] s_next;

  assign load = ~valid | take;

  always_comb begin
    r      = cla4(prev_a[IDX*GROUP_W +: GROUP_W], prev_b[IDX*GROUP_W +: GROUP_W], prev_c);
    s_next = prev_s;
    s_next[IDX*GROUP_W +: GROUP_W] = r.sum;
  end

  // Data only moves with a valid token so outputs stay quiet until real results arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      c_msb_q <= 1'b0;
      sub_q   <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a_q     <= prev_a;
        b_q     <= prev_b;
        s_q     <= s_next;
        c_q     <= r.cout;
        c_msb_q <= r.cmsb;
        sub_q   <= prev_sub;
      end
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit group per stage, valid/ready
// handshake. Optional saturation on overflow when CLA_SAT_EN is defined.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = stages(WIDTH);

  // Index 0 is the prepared input; index k+1 is the register of stage k.
  logic             v    [STAGES+1];
  logic             c    [STAGES+1];
  logic             sb   [STAGES+1];
  logic [WIDTH-1:0] av   [STAGES+1];
  logic [WIDTH-1:0] bv   [STAGES+1];
  logic [WIDTH-1:0] sv   [STAGES+1];
  logic             cm   [STAGES];
  logic             ld   [STAGES];
  logic             take [STAGES];
  logic             ovf_raw;

  assign v[0]     = in_valid;
  assign av[0]    = a;
  assign bv[0]    = sub ? ~b : b;
  assign sv[0]    = '0;
  assign c[0]     = cin ^ sub;
  assign sb[0]    = sub;
  assign in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_last
      assign take[k] = out_ready;
    end else begin : g_mid
      assign take[k] = ld[k+1];
    end

    cla_group_stage #(
      .WIDTH (WIDTH),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (v[k]),
      .take       (take[k]),
      .prev_a     (av[k]),
      .prev_b     (bv[k]),
      .prev_s     (sv[k]),
      .prev_c     (c[k]),
      .prev_sub   (sb[k]),
      .valid      (v[k+1]),
      .load       (ld[k]),
      .a_q        (av[k+1]),
      .b_q        (bv[k+1]),
      .s_q        (sv[k+1]),
      .c_q        (c[k+1]),
      .c_msb_q    (cm[k]),
      .sub_q      (sb[k+1])
    );
  end

  assign out_valid = v[STAGES];
  assign cout      = c[STAGES];
  assign ovf_raw   = (SIGNED != 0) ? (cm[STAGES-1] ^ c[STAGES]) : (c[STAGES] ^ sb[STAGES]);
  assign ovf       = ovf_raw;

`ifdef CLA_SAT_EN
  logic [1:0] pat;
  assign pat = sat_pattern(SIGNED != 0, av[STAGES][WIDTH-1], sb[STAGES]);
  assign s   = ovf_raw ? {pat[1], {(WIDTH-1){pat[0]}}} : sv[STAGES];
`else
  assign s   = sv[STAGES];
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vectors plus an arithmetic reference
// model checked on every output transfer for WIDTH 16/4/32 instances.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic iv16, ir16, ov16, or16, ci16, sb16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic iv4, ir4, ov4, or4, ci4, sb4, co4, of4;
  logic [3:0] a4, b4, s4;
  logic iv32, ir32, ov32, or32, ci32, sb32, co32, of32;
  logic [31:0] a32, b32, s32;

  cla_pipe_adder #(.WIDTH(16), .SIGNED(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .s(s16), .cout(co16), .ovf(of16));
  cla_pipe_adder #(.WIDTH(4), .SIGNED(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(or4), .s(s4), .cout(co4), .ovf(of4));
  cla_pipe_adder #(.WIDTH(32), .SIGNED(0)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .s(s32), .cout(co32), .ovf(of32));

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, s}.
  function automatic logic [65:0] model(input int unsigned w, input bit sgn,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb);
    longint unsigned mask, ua, ub, ur;
    longint sa, sbb, tru, maxv, minv;
    logic co, ov;
    logic [63:0] s;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    sa  = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sbb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    if (!sb) begin
      ur  = ua + ub + 64'(ci);
      co  = ur[w];
      tru = sa + sbb + longint'(ci);
    end else begin
      ur  = ua - ub - 64'(ci);
      co  = (ua >= ub + 64'(ci));
      tru = sa - sbb - longint'(ci);
    end
    ov = sgn ? ((tru > maxv) || (tru < minv)) : (co ^ sb);
    s  = ur & mask;
`ifdef CLA_SAT_EN
    if (ov) s = sgn ? ((tru > maxv) ? 64'(maxv) : (64'(minv) & mask)) : (sb ? 64'd0 : mask);
`endif
    return {ov, co, s};
  endfunction

  logic [65:0] q0[$], q1[$], q2[$];
  bit          hold[3];
  logic [65:0] held[3];
  int          nout[3];

  task automatic flush();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) hold[i] = 1'b0;
  endtask

  task automatic mon(input int id, input int unsigned w, input bit sgn,
                     input logic iv, input logic ir, input logic [63:0] a, input logic [63:0] b,
                     input logic ci, input logic sb, input logic ov, input logic ordy,
                     input logic [63:0] s, input logic co, input logic of);
    logic [65:0] act, e, m;
    bit empty;
    act = {of, co, s};
    if (hold[id]) chk($sformatf("hold_stable_%0d", id), {ov, act}, {1'b1, held[id]});
    if (ov && ordy) begin
      empty = 1'b1;
      case (id)
        0: if (q0.size() != 0) begin empty = 1'b0; e = q0.pop_front(); end
        1: if (q1.size() != 0) begin empty = 1'b0; e = q1.pop_front(); end
        default: if (q2.size() != 0) begin empty = 1'b0; e = q2.pop_front(); end
      endcase
      if (empty) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_%0d actual=%h required=none", id, act);
      end else begin
        chk($sformatf("result_%0d", id), 67'(act), 67'(e));
      end
      nout[id]++;
    end
    hold[id] = ov && !ordy;
    held[id] = act;
    if (iv && ir) begin
      m = model(w, sgn, a, b, ci, sb);
      case (id)
        0: q0.push_back(m);
        1: q1.push_back(m);
        default: q2.push_back(m);
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, 16, 1'b1, iv16, ir16, 64'(a16), 64'(b16), ci16, sb16, ov16, or16, 64'(s16), co16, of16);
      mon(1, 4, 1'b1, iv4, ir4, 64'(a4), 64'(b4), ci4, sb4, ov4, or4, 64'(s4), co4, of4);
      mon(2, 32, 1'b0, iv32, ir32, 64'(a32), 64'(b32), ci32, sb32, ov32, or32, 64'(s32), co32, of32);
    end
  end

  task automatic dir16(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic [17:0] exp);
    int n;
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = a; b16 = b; ci16 = ci; sb16 = sb;
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 1;
    while (!ov16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 67'(n), 67'(4));
    chk(nm, 67'({of16, co16, s16}), 67'(exp));
  endtask

  int  base0, base1, base2, first16, first4, first32;
  bit  bp_done, fired, ok;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {iv16, ci16, sb16, iv4, ci4, sb4, iv32, ci32, sb32} = '0;
    a16 = '0; b16 = '0; a4 = '0; b4 = '0; a32 = '0; b32 = '0;
    or16 = 1'b1; or4 = 1'b1; or32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 67'({ov16, s16, co16, of16}), 67'(0));
    rst_n = 1'b1;
    chk("in_ready_after_reset", 67'(ir16), 67'(1));

    // Reset mid-stream: three ops in flight, then a one-cycle reset pulse.
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111;
    @(posedge clk); #1; a16 = 16'h4321; b16 = 16'h0F0F;
    @(posedge clk); #1; a16 = 16'hAAAA; b16 = 16'h5555;
    @(posedge clk); #1;
    iv16 = 1'b0; rst_n = 1'b0; flush();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("reset_no_stale", 67'(ov16), 67'(0));
      @(posedge clk); #1;
    end

    dir16("one_plus_one", 16'h0001, 16'h0001, 1'b0, 1'b0, 18'h00002);
    dir16("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    dir16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    dir16("sub_borrow_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFD);
`ifdef CLA_SAT_EN
    dir16("signed_ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h27FFF);
    dir16("signed_ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 18'h38000);
    chk("model_pin_u4", 67'(model(4, 1'b1, 64'h7, 64'h1, 1'b0, 1'b0)), 67'(66'h2_0000_0000_0000_0007));
    chk("model_pin_u32", 67'(model(32, 1'b0, 64'h5, 64'h7, 1'b0, 1'b1)), 67'(66'h2_0000_0000_0000_0000));
`else
    dir16("signed_ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    dir16("signed_ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    chk("model_pin_u4", 67'(model(4, 1'b1, 64'h7, 64'h1, 1'b0, 1'b0)), 67'(66'h2_0000_0000_0000_0008));
    chk("model_pin_u32", 67'(model(32, 1'b0, 64'h5, 64'h7, 1'b0, 1'b1)), 67'(66'h2_0000_0000_FFFF_FFFE));
`endif
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: random gaps on input, random out_ready.
    base0 = nout[0];
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          iv16 = 1'b0;
          repeat ($urandom_range(2)) begin @(posedge clk); #1; end
          iv16 = 1'b1;
          a16 = 16'($urandom); b16 = 16'($urandom);
          ci16 = 1'($urandom); sb16 = 1'($urandom);
          ok = 1'b0;
          for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            fired = ir16;
            @(posedge clk); #1;
            if (fired) begin ok = 1'b1; break; end
          end
          if (!ok) begin
            checks++;
            failures++;
            $display("FAIL bp_input_accept actual=stuck required=accepted");
          end
        end
        iv16 = 1'b0;
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          or16 = 1'($urandom);
          @(posedge clk); #1;
        end
        or16 = 1'b1;
      end
    join
    for (int t = 0; t < 100 && (nout[0] - base0) < 20; t++) @(posedge clk);
    #1;
    chk("bp_result_count", 67'(nout[0] - base0), 67'(20));
    repeat (10) @(posedge clk);
    #1;

    // Full throughput on all three widths.
    base0 = nout[0]; base1 = nout[1]; base2 = nout[2];
    first16 = -1; first4 = -1; first32 = -1;
    iv16 = 1'b1; iv4 = 1'b1; iv32 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (ov16 && first16 < 0) first16 = i;
      if (ov4 && first4 < 0) first4 = i;
      if (ov32 && first32 < 0) first32 = i;
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); sb16 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); sb4 = 1'($urandom);
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); sb32 = 1'($urandom);
      chk("tp_in_ready_16", 67'(ir16), 67'(1));
      chk("tp_in_ready_4", 67'(ir4), 67'(1));
      chk("tp_in_ready_32", 67'(ir32), 67'(1));
      @(posedge clk); #1;
    end
    iv16 = 1'b0; iv4 = 1'b0; iv32 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("tp_latency_16", 67'(first16), 67'(4));
    chk("tp_latency_4", 67'(first4), 67'(1));
    chk("tp_latency_32", 67'(first32), 67'(8));
    chk("tp_count_16", 67'(nout[0] - base0), 67'(50));
    chk("tp_count_4", 67'(nout[1] - base1), 67'(50));
    chk("tp_count_32", 67'(nout[2] - base2), 67'(50));
    chk("tp_queue_empty", 67'(q0.size() + q1.size() + q2.size()), 67'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
